// File: rtl/branches_pkg.sv
// Branch comparison encodings shared by decode, execute and the branch unit.
// Pure type package; no logic.
// Encoding value 0 (BR_EQ) doubles as the idle/reset branch op.
package branches_pkg;

  typedef enum logic [2:0] {
    BR_EQ  = 3'd0,
    BR_NE  = 3'd1,
    BR_LT  = 3'd2,
    BR_GE  = 3'd3,
    BR_LTU = 3'd4,
    BR_GEU = 3'd5
  } branch_op_e;

endpackage

// File: rtl/lx32_pkg.sv
// Core-wide types: ALU op encoding and the decode->execute pipeline payload.
// Pure type package; no logic.
// ALU_ADD is encoding 0 so an all-zero payload is a harmless reset value.
package lx32_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  // One decoded instruction as held between ID and EX. Source addresses travel
  // with the data so the held operands can keep being refreshed by forwarding.
  typedef struct packed {
    logic [XLEN-1:0]          pc;
    logic [XLEN-1:0]          imm;
    logic [REG_AW-1:0]        rs1_addr;
    logic [REG_AW-1:0]        rs2_addr;
    logic [XLEN-1:0]          rs1_data;
    logic [XLEN-1:0]          rs2_data;
    logic                     src_a_pc;
    logic                     src_b_imm;
    alu_op_e                  alu_op;
    logic                     is_branch;
    branches_pkg::branch_op_e branch_op;
    logic [REG_AW-1:0]        rd_addr;
    logic                     reg_write;
  } id_ex_t;

  localparam id_ex_t ID_EX_RESET = '0;

endpackage

// File: rtl/fwd_mux.sv
// Resolves one source operand against the MEM and WB writeback ports.
// Latency: combinational.
// Backpressure: none; pure datapath.
module fwd_mux #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]      raw_data,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [WIDTH-1:0]      mem_data,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [WIDTH-1:0]      wb_data,
  output logic [WIDTH-1:0]      fwd_data
);

  // Youngest producer wins: MEM over WB over register file; x0 never forwards.
  always_comb begin
    fwd_data = raw_data;
    if (addr != '0) begin
      if (mem_valid && (mem_rd == addr)) begin
        fwd_data = mem_data;
      end else if (wb_valid && (wb_rd == addr)) begin
        fwd_data = wb_data;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with operand forwarding, load-use hold and flush.
// Latency: 1 cycle capture-to-present; full throughput back-to-back.
// Backpressure: id_ready drops while FULL and not consumed (incl. load-use).
// Optional: LX32_EX_STALL_CNT_EN adds a saturating stall_cycles counter.
module id_ex_stage
  import lx32_pkg::*;
  import branches_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [WIDTH-1:0]      id_pc,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic [WIDTH-1:0]      id_rs1_data,
  input  logic [WIDTH-1:0]      id_rs2_data,
  input  logic [WIDTH-1:0]      id_imm,
  input  logic                  id_src_a_pc,
  input  logic                  id_src_b_imm,
  input  alu_op_e               id_alu_op,
  input  logic                  id_is_branch,
  input  branch_op_e            id_branch_op,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  id_reg_write,
  input  logic                  flush,
  input  logic                  mem_fwd_valid,
  input  logic                  mem_fwd_is_load,
  input  logic [REG_ADDR_W-1:0] mem_fwd_rd,
  input  logic [WIDTH-1:0]      mem_fwd_data,
  input  logic                  wb_fwd_valid,
  input  logic [REG_ADDR_W-1:0] wb_fwd_rd,
  input  logic [WIDTH-1:0]      wb_fwd_data,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [WIDTH-1:0]      src_a,
  output logic [WIDTH-1:0]      src_b,
  output alu_op_e               alu_control,
  output logic                  is_branch,
  output branch_op_e            branch_op,
  output logic [WIDTH-1:0]      ex_pc,
  output logic [WIDTH-1:0]      ex_rs2_data,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic                  ex_reg_write,
  output logic                  load_use_stall
`ifdef LX32_EX_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  id_ex_t           held;
  id_ex_t           incoming;
  logic             held_valid;
  logic             capture;
  logic             consume;
  logic [WIDTH-1:0] cap_rs1, cap_rs2;
  logic [WIDTH-1:0] cur_rs1, cur_rs2;

  // Incoming operands are resolved against the producers visible this cycle.
  fwd_mux #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_cap_rs1 (
    .addr(id_rs1_addr), .raw_data(id_rs1_data),
    .mem_valid(mem_fwd_valid), .mem_rd(mem_fwd_rd), .mem_data(mem_fwd_data),
    .wb_valid(wb_fwd_valid), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data),
    .fwd_data(cap_rs1)
  );

  fwd_mux #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_cap_rs2 (
    .addr(id_rs2_addr), .raw_data(id_rs2_data),
    .mem_valid(mem_fwd_valid), .mem_rd(mem_fwd_rd), .mem_data(mem_fwd_data),
    .wb_valid(wb_fwd_valid), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data),
    .fwd_data(cap_rs2)
  );

  // Held operands are re-resolved every cycle: the producer that was in EX at
  // capture time sits in MEM now, so the ALU must see the forwarded value live
  // and the register is rewritten with it for the following cycles.
  fwd_mux #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_hold_rs1 (
    .addr(held.rs1_addr), .raw_data(held.rs1_data),
    .mem_valid(mem_fwd_valid), .mem_rd(mem_fwd_rd), .mem_data(mem_fwd_data),
    .wb_valid(wb_fwd_valid), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data),
    .fwd_data(cur_rs1)
  );

  fwd_mux #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_hold_rs2 (
    .addr(held.rs2_addr), .raw_data(held.rs2_data),
    .mem_valid(mem_fwd_valid), .mem_rd(mem_fwd_rd), .mem_data(mem_fwd_data),
    .wb_valid(wb_fwd_valid), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data),
    .fwd_data(cur_rs2)
  );

  // A load still in MEM cannot supply data yet; hold until it reaches WB.
  assign load_use_stall = held_valid && mem_fwd_valid && mem_fwd_is_load &&
                          (mem_fwd_rd != '0) &&
                          ((mem_fwd_rd == held.rs1_addr) || (mem_fwd_rd == held.rs2_addr));
  assign ex_valid = held_valid && !load_use_stall;
  assign consume  = ex_valid && ex_ready;
  assign id_ready = !held_valid || consume;
  assign capture  = id_valid && id_ready;

  // Pack the decode-side fields with their forwarded source data.
  always_comb begin
    incoming           = ID_EX_RESET;
    incoming.pc        = id_pc;
    incoming.imm       = id_imm;
    incoming.rs1_addr  = id_rs1_addr;
    incoming.rs2_addr  = id_rs2_addr;
    incoming.rs1_data  = cap_rs1;
    incoming.rs2_data  = cap_rs2;
    incoming.src_a_pc  = id_src_a_pc;
    incoming.src_b_imm = id_src_b_imm;
    incoming.alu_op    = id_alu_op;
    incoming.is_branch = id_is_branch;
    incoming.branch_op = id_branch_op;
    incoming.rd_addr   = id_rd_addr;
    incoming.reg_write = id_reg_write;
  end

  // Single-entry register: flush kills both held and incoming; otherwise
  // capture, drain, or refresh the held operands in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_valid <= 1'b0;
      held       <= ID_EX_RESET;
    end else begin
      if (flush) begin
        held_valid <= 1'b0;
      end else if (capture) begin
        held_valid <= 1'b1;
      end else if (consume) begin
        held_valid <= 1'b0;
      end

      if (capture && !flush) begin
        held <= incoming;
      end else begin
        held.rs1_data <= cur_rs1;
        held.rs2_data <= cur_rs2;
      end
    end
  end

  assign src_a        = held.src_a_pc  ? held.pc  : cur_rs1;
  assign src_b        = held.src_b_imm ? held.imm : cur_rs2;
  assign ex_rs2_data  = cur_rs2;
  assign alu_control  = held.alu_op;
  assign is_branch    = held.is_branch;
  assign branch_op    = held.branch_op;
  assign ex_pc        = held.pc;
  assign ex_rd_addr   = held.rd_addr;
  assign ex_reg_write = held.reg_write;

`ifdef LX32_EX_STALL_CNT_EN
  // Count cycles an instruction sits here without issuing; saturates, reset-only clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (held_valid && (!ex_ready || load_use_stall) && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: scoreboard of issued operands plus inline checks.
// Latency: expects issue one cycle after capture.
// Backpressure: exercises ex_ready stalls, load-use hold and flush.
module tb_id_ex_stage;
  import lx32_pkg::*;
  import branches_pkg::*;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rs2d;
    logic [4:0]  rd;
    logic [3:0]  alu;
  } exp_t;

  logic        clk, rst_n;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        id_src_a_pc, id_src_b_imm, id_is_branch, id_reg_write;
  alu_op_e     id_alu_op;
  branch_op_e  id_branch_op;
  logic        flush;
  logic        mem_fwd_valid, mem_fwd_is_load, wb_fwd_valid;
  logic [4:0]  mem_fwd_rd, wb_fwd_rd;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        ex_valid, ex_ready;
  logic [31:0] src_a, src_b, ex_pc, ex_rs2_data;
  alu_op_e     alu_control;
  logic        is_branch;
  branch_op_e  branch_op;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write, load_use_stall;
`ifdef LX32_EX_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int   tests_run;
  int   tests_failed;
  exp_t sb[$];

  id_ex_stage #(.WIDTH(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_src_a_pc(id_src_a_pc), .id_src_b_imm(id_src_b_imm), .id_alu_op(id_alu_op),
    .id_is_branch(id_is_branch), .id_branch_op(id_branch_op),
    .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write), .flush(flush),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_is_load(mem_fwd_is_load),
    .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .src_a(src_a), .src_b(src_b),
    .alu_control(alu_control), .is_branch(is_branch), .branch_op(branch_op),
    .ex_pc(ex_pc), .ex_rs2_data(ex_rs2_data), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .load_use_stall(load_use_stall)
`ifdef LX32_EX_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    id_valid = 0; id_pc = 0; id_rs1_addr = 0; id_rs2_addr = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_src_a_pc = 0;
    id_src_b_imm = 0; id_alu_op = ALU_ADD; id_is_branch = 0;
    id_branch_op = BR_EQ; id_rd_addr = 0; id_reg_write = 0; flush = 0;
    mem_fwd_valid = 0; mem_fwd_is_load = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
    wb_fwd_valid = 0; wb_fwd_rd = 0; wb_fwd_data = 0; ex_ready = 1;
  endtask

  task automatic drive_instr(input logic [31:0] pc, input logic [4:0] rs1a,
                             input logic [31:0] rs1d, input logic [4:0] rs2a,
                             input logic [31:0] rs2d, input logic [31:0] imm,
                             input logic sa, input logic sbi, input alu_op_e op,
                             input logic [4:0] rd);
    id_valid = 1; id_pc = pc; id_rs1_addr = rs1a; id_rs1_data = rs1d;
    id_rs2_addr = rs2a; id_rs2_data = rs2d; id_imm = imm; id_src_a_pc = sa;
    id_src_b_imm = sbi; id_alu_op = op; id_rd_addr = rd; id_reg_write = 1;
    id_is_branch = 0; id_branch_op = BR_EQ;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] rs2d, input logic [4:0] rd,
                          input alu_op_e op);
    exp_t e;
    e.a = a; e.b = b; e.rs2d = rs2d; e.rd = rd; e.alu = op;
    sb.push_back(e);
  endtask

  // Observe at the falling edge; any issue (ex_valid && ex_ready) pops the scoreboard.
  task automatic sample();
    exp_t e, o;
    @(negedge clk);
    if (ex_valid && ex_ready) begin
      tests_run++;
      o.a = src_a; o.b = src_b; o.rs2d = ex_rs2_data; o.rd = ex_rd_addr; o.alu = alu_control;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL issue_unexpected got a=%h b=%h rd=%0d, required no issue", src_a, src_b, ex_rd_addr);
      end else begin
        e = sb.pop_front();
        if (o !== e) begin
          tests_failed++;
          $display("FAIL issue got a=%h b=%h rs2d=%h rd=%0d alu=%0d required a=%h b=%h rs2d=%h rd=%0d alu=%0d",
                   o.a, o.b, o.rs2d, o.rd, o.alu, e.a, e.b, e.rs2d, e.rd, e.alu);
        end
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    sample();
    tests_run++;
    if (ex_valid !== 1'b0 || load_use_stall !== 1'b0 || id_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ctrl got ex_valid=%b lus=%b id_ready=%b required 0 0 1", ex_valid, load_use_stall, id_ready);
    end
    tests_run++;
    if ({src_a, src_b, ex_pc, ex_rs2_data, ex_rd_addr} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data got a=%h b=%h pc=%h rs2=%h rd=%0d required all 0", src_a, src_b, ex_pc, ex_rs2_data, ex_rd_addr);
    end
    tests_run++;
    if (alu_control !== ALU_ADD || branch_op !== BR_EQ || is_branch !== 1'b0 || ex_reg_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctl_fields got alu=%0d br=%0d isb=%b rw=%b required 0 0 0 0", alu_control, branch_op, is_branch, ex_reg_write);
    end
`ifdef LX32_EX_STALL_CNT_EN
    tests_run++;
    if (stall_cycles !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_stall_cnt got %0d required 0", stall_cycles);
    end
`endif
    rst_n = 1;
    adv();
  endtask

  task automatic test_basic_add();
    drive_instr(32'h40, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 0, 0, ALU_ADD, 5'd3);
    push_exp(32'd5, 32'd7, 32'd7, 5'd3, ALU_ADD);
    sample();
    adv();
    idle_inputs();
    sample();
    tests_run++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h40) begin
      tests_failed++;
      $display("FAIL basic_add_valid got ex_valid=%b pc=%h required 1 00000040", ex_valid, ex_pc);
    end
    adv();
  endtask

  task automatic test_fwd_priority();
    // MEM beats WB
    drive_instr(32'h44, 5'd3, 32'h1111, 5'd0, 32'h22, 32'd0, 0, 0, ALU_OR, 5'd8);
    mem_fwd_valid = 1; mem_fwd_rd = 5'd3; mem_fwd_data = 32'hAAAA;
    wb_fwd_valid = 1; wb_fwd_rd = 5'd3; wb_fwd_data = 32'hBBBB;
    push_exp(32'hAAAA, 32'h22, 32'h22, 5'd8, ALU_OR);
    sample(); adv();
    // WB beats register file when MEM writes a different register
    drive_instr(32'h48, 5'd6, 32'h1, 5'd7, 32'h2, 32'd0, 0, 0, ALU_XOR, 5'd9);
    mem_fwd_valid = 1; mem_fwd_rd = 5'd10; mem_fwd_data = 32'hCCCC;
    wb_fwd_valid = 1; wb_fwd_rd = 5'd7; wb_fwd_data = 32'hBBBB;
    push_exp(32'h1, 32'hBBBB, 32'hBBBB, 5'd9, ALU_XOR);
    sample(); adv();
    // x0 never forwards, valid rows with rd=0 are ignored
    drive_instr(32'h4C, 5'd0, 32'h77, 5'd0, 32'h66, 32'd0, 0, 0, ALU_AND, 5'd11);
    mem_fwd_valid = 1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'h1234;
    wb_fwd_valid = 1; wb_fwd_rd = 5'd0; wb_fwd_data = 32'h1234;
    push_exp(32'h77, 32'h66, 32'h66, 5'd11, ALU_AND);
    sample(); adv();
    idle_inputs();
    sample(); adv();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive_instr(32'h200 + 32'(i * 4), 5'd12, 32'(100 + i), 5'd13, 32'(200 + i),
                  32'd0, 0, 0, ALU_SUB, 5'(20 + i));
      push_exp(32'(100 + i), 32'(200 + i), 32'(200 + i), 5'(20 + i), ALU_SUB);
      sample();
      tests_run++;
      if (id_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_ready[%0d] got %b required 1", i, id_ready);
      end
      adv();
    end
    idle_inputs();
    sample(); adv();
  endtask

  task automatic test_stall_refresh();
    int issues;
    issues = 0;
    drive_instr(32'h300, 5'd1, 32'h10, 5'd9, 32'h20, 32'd0, 0, 0, ALU_ADD, 5'd4);
    ex_ready = 0;
    push_exp(32'h10, 32'h55, 32'h55, 5'd4, ALU_ADD);
    sample(); adv();
    // A second instruction waits at the input for the whole stall.
    drive_instr(32'h304, 5'd2, 32'h30, 5'd3, 32'h40, 32'd0, 0, 0, ALU_OR, 5'd5);
    ex_ready = 0;
    for (int c = 0; c < 3; c++) begin
      wb_fwd_valid = (c == 0); wb_fwd_rd = 5'd9; wb_fwd_data = 32'h55;
      sample();
      tests_run++;
      if (id_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_id_ready[%0d] got %b required 0", c, id_ready);
      end
      adv();
    end
    wb_fwd_valid = 0; id_valid = 0; ex_ready = 1;
    sample();
    if (ex_valid) issues++;
    adv();
    idle_inputs();
    sample();
    if (ex_valid) issues++;
    tests_run++;
    if (issues !== 1) begin
      tests_failed++;
      $display("FAIL stall_issue_count got %0d required 1", issues);
    end
    adv();
  endtask

  task automatic test_load_use();
    drive_instr(32'h400, 5'd4, 32'h1, 5'd5, 32'h2, 32'd0, 0, 0, ALU_ADD, 5'd6);
    push_exp(32'h99, 32'h2, 32'h2, 5'd6, ALU_ADD);
    sample(); adv();
    idle_inputs();
    mem_fwd_valid = 1; mem_fwd_is_load = 1; mem_fwd_rd = 5'd4; mem_fwd_data = 32'hDEAD;
    sample();
    tests_run++;
    if (load_use_stall !== 1'b1 || ex_valid !== 1'b0 || id_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_use_hold got lus=%b ex_valid=%b id_ready=%b required 1 0 0", load_use_stall, ex_valid, id_ready);
    end
    adv();
    idle_inputs();
    wb_fwd_valid = 1; wb_fwd_rd = 5'd4; wb_fwd_data = 32'h99;
    sample();
    tests_run++;
    if (load_use_stall !== 1'b0 || ex_valid !== 1'b1 || src_a !== 32'h99) begin
      tests_failed++;
      $display("FAIL load_use_release got lus=%b ex_valid=%b src_a=%h required 0 1 00000099", load_use_stall, ex_valid, src_a);
    end
    adv();
    idle_inputs();
  endtask

  task automatic test_flush();
    drive_instr(32'h500, 5'd1, 32'h1, 5'd2, 32'h2, 32'd0, 0, 0, ALU_ADD, 5'd7);
    ex_ready = 0;
    sample(); adv();
    drive_instr(32'h504, 5'd1, 32'h3, 5'd2, 32'h4, 32'd0, 0, 0, ALU_ADD, 5'd8);
    ex_ready = 0; flush = 1;
    sample();
    tests_run++;
    if (ex_valid !== 1'b1 || id_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_cycle got ex_valid=%b id_ready=%b required 1 0", ex_valid, id_ready);
    end
    adv();
    idle_inputs();
    sample();
    tests_run++;
    if (ex_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_full_after got ex_valid=%b required 0", ex_valid);
    end
    // Flush while empty: id_ready stays high but the capture is dropped.
    drive_instr(32'h508, 5'd1, 32'h5, 5'd2, 32'h6, 32'd0, 0, 0, ALU_ADD, 5'd9);
    flush = 1;
    sample();
    tests_run++;
    if (id_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_empty_ready got %b required 1", id_ready);
    end
    adv();
    idle_inputs();
    sample();
    tests_run++;
    if (ex_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_empty_after got ex_valid=%b required 0", ex_valid);
    end
    adv();
  endtask

  task automatic test_imm_pc();
    drive_instr(32'h100, 5'd1, 32'h3, 5'd2, 32'h4, 32'd8, 1, 1, ALU_SUB, 5'd10);
    id_is_branch = 1; id_branch_op = BR_LT;
    push_exp(32'h100, 32'd8, 32'h4, 5'd10, ALU_SUB);
    sample(); adv();
    idle_inputs();
    sample();
    tests_run++;
    if (is_branch !== 1'b1 || branch_op !== BR_LT || ex_reg_write !== 1'b1) begin
      tests_failed++;
      $display("FAIL imm_pc_branch got isb=%b br=%0d rw=%b required 1 2 1", is_branch, branch_op, ex_reg_write);
    end
    adv();
  endtask

  task automatic test_reset_mid();
    drive_instr(32'h600, 5'd1, 32'h1, 5'd2, 32'h2, 32'd0, 0, 0, ALU_ADD, 5'd3);
    ex_ready = 0;
    sample(); adv();
    idle_inputs(); ex_ready = 0;
    sample();
    #1 rst_n = 0;
    #1;
    tests_run++;
    if (ex_valid !== 1'b0 || src_a !== 32'd0 || id_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid got ex_valid=%b src_a=%h id_ready=%b required 0 0 1", ex_valid, src_a, id_ready);
    end
    #1 rst_n = 1;
    adv();
    idle_inputs();
  endtask

`ifdef LX32_EX_STALL_CNT_EN
  task automatic test_stall_cnt();
    logic [31:0] base;
    drive_instr(32'h700, 5'd1, 32'h11, 5'd2, 32'h22, 32'd0, 0, 0, ALU_ADD, 5'd5);
    ex_ready = 0;
    push_exp(32'h11, 32'h22, 32'h22, 5'd5, ALU_ADD);
    sample();
    base = stall_cycles;
    adv();
    idle_inputs(); ex_ready = 0;
    repeat (4) begin
      sample(); adv();
    end
    ex_ready = 1;
    sample();
    tests_run++;
    if (stall_cycles - base !== 32'd4) begin
      tests_failed++;
      $display("FAIL stall_cnt got %0d required 4", stall_cycles - base);
    end
    adv();
  endtask
`endif

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_basic_add();
    test_fwd_priority();
    test_back_to_back();
    test_stall_refresh();
    test_load_use();
    test_flush();
    test_imm_pc();
    test_reset_mid();
`ifdef LX32_EX_STALL_CNT_EN
    test_stall_cnt();
`endif
    tests_run++;
    if (sb.size() !== 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
